dc_victim_select: RTL and testbench

//  Miss-side stage directly downstream of the DC tag-check banks. Accepts one tag miss at a time,

---
 rtl/dc_victim_pkg.sv | 32 +++
 rtl/dc_victim_pick.sv | 49 ++++
 rtl/dc_victim_select.sv | 207 ++++++++++++++++++++
 tb/tb_dc_victim_select.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_victim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : dc_victim_pkg                                                    |
// | Desc    : Coherence state / L2 command encodings and FSM states shared by  |
// |           the DC victim-select miss stage.                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package dc_victim_pkg;

    localparam logic [2:0] ST_I = 3'd0;
    localparam logic [2:0] ST_S = 3'd1;
    localparam logic [2:0] ST_M = 3'd2;

    localparam logic [1:0] CMD_FILL_S = 2'd0;
    localparam logic [1:0] CMD_FILL_M = 2'd1;
    localparam logic [1:0] CMD_WB     = 2'd2;

    localparam int RRPV_BITS_DEFAULT = 2;
    localparam int RRPV_MAX          = (1 << RRPV_BITS_DEFAULT) - 1;

    typedef enum logic [2:0] {
        FSM_IDLE = 3'd0,
        FSM_RD   = 3'd1,
        FSM_WAIT = 3'd2,
        FSM_SEL  = 3'd3,
        FSM_UPD  = 3'd4,
        FSM_WB   = 3'd5,
        FSM_FILL = 3'd6
    } fsm_e;

endpackage
`default_nettype wire

// File: rtl/dc_victim_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dc_victim_pick                                                   |
// | Desc    : Combinational victim priority pick: lowest invalid way, else     |
// |           lowest way at maximum RRPV.                                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dc_victim_pick
    import dc_victim_pkg::*;
#(
    parameter int WAYS      = 8,
    parameter int RRPV_BITS = 2
) (
    input  logic [3*WAYS-1:0]         i_state_vec,
    input  logic [RRPV_BITS*WAYS-1:0] i_rrpv_vec,
    output logic                      o_found,
    output logic [$clog2(WAYS)-1:0]   o_way
);

    localparam int WAY_BITS = $clog2(WAYS);
    localparam logic [RRPV_BITS-1:0] c_RRPV_MAX = '1;

    logic                w_inv_hit;
    logic                w_max_hit;
    logic [WAY_BITS-1:0] w_inv_way;
    logic [WAY_BITS-1:0] w_max_way;

    // Scan from the top so the last hit recorded is the lowest index.
    always_comb begin
        w_inv_hit = 1'b0;
        w_max_hit = 1'b0;
        w_inv_way = '0;
        w_max_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (i_state_vec[3*i +: 3] == ST_I) begin
                w_inv_hit = 1'b1;
                w_inv_way = WAY_BITS'(i);
            end
            if (i_rrpv_vec[RRPV_BITS*i +: RRPV_BITS] == c_RRPV_MAX) begin
                w_max_hit = 1'b1;
                w_max_way = WAY_BITS'(i);
            end
        end
        o_found = w_inv_hit | w_max_hit;
        o_way   = w_inv_hit ? w_inv_way : w_max_way;
    end

endmodule
`default_nettype wire

// File: rtl/dc_victim_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dc_victim_select                                                 |
// | Desc    : DC miss stage: set read, RRIP victim select with aging, tag      |
// |           update, optional dirty writeback and L2 fill request.            |
// |           DC_VICTIM_BRRIP_EN enables bimodal insertion via miss counter.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dc_victim_select
    import dc_victim_pkg::*;
#(
    parameter int SET_BITS  = 5,
    parameter int TAG_BITS  = 18,
    parameter int WAYS      = 8,
    parameter int RRPV_BITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          miss_valid,
    output logic                          miss_retry,
    input  logic [SET_BITS-1:0]           miss_set,
    input  logic [TAG_BITS-1:0]           miss_tag,
    input  logic                          miss_store,
    output logic                          tag_rd_valid,
    output logic [SET_BITS-1:0]           tag_rd_set,
    input  logic                          tag_rd_ack,
    input  logic [3*WAYS-1:0]             tag_rd_state,
    input  logic [RRPV_BITS*WAYS-1:0]     tag_rd_rrpv,
    input  logic [TAG_BITS*WAYS-1:0]      tag_rd_tag,
    output logic                          tag_wr_valid,
    output logic [SET_BITS-1:0]           tag_wr_set,
    output logic [RRPV_BITS*WAYS-1:0]     tag_wr_rrpv,
    output logic [$clog2(WAYS)-1:0]       tag_wr_way,
    output logic [TAG_BITS-1:0]           tag_wr_tag,
    output logic [2:0]                    tag_wr_state,
    output logic                          l2_req_valid,
    input  logic                          l2_req_retry,
    output logic [1:0]                    l2_req_cmd,
    output logic [TAG_BITS+SET_BITS-1:0]  l2_req_addr,
    output logic [$clog2(WAYS)-1:0]       l2_req_way,
    output logic                          busy
);

    localparam int WAY_BITS = $clog2(WAYS);
    localparam logic [RRPV_BITS-1:0] c_RRPV_MAX  = '1;
    localparam logic [RRPV_BITS-1:0] c_INS_NEAR  = RRPV_BITS'((1 << RRPV_BITS) - 2);

    fsm_e                         r_fsm;
    logic [SET_BITS-1:0]          r_set;
    logic [TAG_BITS-1:0]          r_tag;
    logic                         r_store;
    logic [RRPV_BITS-1:0]         r_ins;
    logic [3*WAYS-1:0]            r_state_vec;
    logic [RRPV_BITS*WAYS-1:0]    r_rrpv_vec;
    logic [TAG_BITS*WAYS-1:0]     r_tag_vec;
    logic [2:0]                   r_old_state;
    logic [TAG_BITS-1:0]          r_old_tag;
    logic [WAY_BITS-1:0]          r_vict_way;

    logic                         w_found;
    logic [WAY_BITS-1:0]          w_way;
    logic [RRPV_BITS*WAYS-1:0]    w_aged;
    logic [RRPV_BITS*WAYS-1:0]    w_wr_rrpv;
    logic [RRPV_BITS-1:0]         w_ins;
    logic                         w_accept;

    assign busy       = (r_fsm != FSM_IDLE);
    assign miss_retry = busy;
    assign w_accept   = (r_fsm == FSM_IDLE) && miss_valid;

`ifdef DC_VICTIM_BRRIP_EN
    logic [4:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            r_miss_cnt <= r_miss_cnt + 5'd1;
        end
    end

    assign w_ins = (r_miss_cnt == 5'd0) ? c_INS_NEAR : c_RRPV_MAX;
`else
    assign w_ins = c_INS_NEAR;
`endif

    dc_victim_pick #(
        .WAYS      (WAYS),
        .RRPV_BITS (RRPV_BITS)
    ) u_pick (
        .i_state_vec (r_state_vec),
        .i_rrpv_vec  (r_rrpv_vec),
        .o_found     (w_found),
        .o_way       (w_way)
    );

    // No way is at max when aging runs, so +1 never wraps.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
        assign w_aged[gi*RRPV_BITS +: RRPV_BITS] =
            r_rrpv_vec[gi*RRPV_BITS +: RRPV_BITS] + RRPV_BITS'(1);
    end

    always_comb begin
        w_wr_rrpv = r_rrpv_vec;
        w_wr_rrpv[RRPV_BITS*w_way +: RRPV_BITS] = r_ins;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm        <= FSM_IDLE;
            r_set        <= '0;
            r_tag        <= '0;
            r_store      <= 1'b0;
            r_ins        <= '0;
            r_state_vec  <= '0;
            r_rrpv_vec   <= '0;
            r_tag_vec    <= '0;
            r_old_state  <= '0;
            r_old_tag    <= '0;
            r_vict_way   <= '0;
            tag_rd_valid <= 1'b0;
            tag_rd_set   <= '0;
            tag_wr_valid <= 1'b0;
            tag_wr_set   <= '0;
            tag_wr_rrpv  <= '0;
            tag_wr_way   <= '0;
            tag_wr_tag   <= '0;
            tag_wr_state <= '0;
            l2_req_valid <= 1'b0;
            l2_req_cmd   <= '0;
            l2_req_addr  <= '0;
            l2_req_way   <= '0;
        end else begin
            case (r_fsm)
                FSM_IDLE: begin
                    if (miss_valid) begin
                        r_set        <= miss_set;
                        r_tag        <= miss_tag;
                        r_store      <= miss_store;
                        r_ins        <= w_ins;
                        tag_rd_valid <= 1'b1;
                        tag_rd_set   <= miss_set;
                        r_fsm        <= FSM_RD;
                    end
                end
                FSM_RD: begin
                    tag_rd_valid <= 1'b0;
                    r_fsm        <= FSM_WAIT;
                end
                FSM_WAIT: begin
                    if (tag_rd_ack) begin
                        r_state_vec <= tag_rd_state;
                        r_rrpv_vec  <= tag_rd_rrpv;
                        r_tag_vec   <= tag_rd_tag;
                        r_fsm       <= FSM_SEL;
                    end
                end
                FSM_SEL: begin
                    if (w_found) begin
                        tag_wr_valid <= 1'b1;
                        tag_wr_set   <= r_set;
                        tag_wr_rrpv  <= w_wr_rrpv;
                        tag_wr_way   <= w_way;
                        tag_wr_tag   <= r_tag;
                        tag_wr_state <= r_store ? ST_M : ST_S;
                        r_old_state  <= r_state_vec[3*w_way +: 3];
                        r_old_tag    <= r_tag_vec[TAG_BITS*w_way +: TAG_BITS];
                        r_vict_way   <= w_way;
                        r_fsm        <= FSM_UPD;
                    end else begin
                        r_rrpv_vec <= w_aged;
                    end
                end
                FSM_UPD: begin
                    tag_wr_valid <= 1'b0;
                    l2_req_valid <= 1'b1;
                    l2_req_way   <= r_vict_way;
                    if (r_old_state == ST_M) begin
                        l2_req_cmd  <= CMD_WB;
                        l2_req_addr <= {r_old_tag, r_set};
                        r_fsm       <= FSM_WB;
                    end else begin
                        l2_req_cmd  <= r_store ? CMD_FILL_M : CMD_FILL_S;
                        l2_req_addr <= {r_tag, r_set};
                        r_fsm       <= FSM_FILL;
                    end
                end
                FSM_WB: begin
                    if (!l2_req_retry) begin
                        l2_req_cmd  <= r_store ? CMD_FILL_M : CMD_FILL_S;
                        l2_req_addr <= {r_tag, r_set};
                        r_fsm       <= FSM_FILL;
                    end
                end
                FSM_FILL: begin
                    if (!l2_req_retry) begin
                        l2_req_valid <= 1'b0;
                        r_fsm        <= FSM_IDLE;
                    end
                end
                default: r_fsm <= FSM_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dc_victim_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dc_victim_select                                              |
// | Desc    : Self-checking bench: vector table, scoreboard queue of expected  |
// |           tag writes / L2 requests, stall, reset-abort and BRRIP sequences.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_dc_victim_select;
    import dc_victim_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         miss_valid, miss_retry, miss_store;
    logic [4:0]   miss_set;
    logic [17:0]  miss_tag;
    logic         tag_rd_valid, tag_rd_ack;
    logic [4:0]   tag_rd_set;
    logic [23:0]  tag_rd_state;
    logic [15:0]  tag_rd_rrpv;
    logic [143:0] tag_rd_tag;
    logic         tag_wr_valid;
    logic [4:0]   tag_wr_set;
    logic [15:0]  tag_wr_rrpv;
    logic [2:0]   tag_wr_way, tag_wr_state, l2_req_way;
    logic [17:0]  tag_wr_tag;
    logic         l2_req_valid, l2_req_retry, busy;
    logic [1:0]   l2_req_cmd;
    logic [22:0]  l2_req_addr;

    dc_victim_select dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_set(miss_set),
        .miss_tag(miss_tag), .miss_store(miss_store),
        .tag_rd_valid(tag_rd_valid), .tag_rd_set(tag_rd_set), .tag_rd_ack(tag_rd_ack),
        .tag_rd_state(tag_rd_state), .tag_rd_rrpv(tag_rd_rrpv), .tag_rd_tag(tag_rd_tag),
        .tag_wr_valid(tag_wr_valid), .tag_wr_set(tag_wr_set), .tag_wr_rrpv(tag_wr_rrpv),
        .tag_wr_way(tag_wr_way), .tag_wr_tag(tag_wr_tag), .tag_wr_state(tag_wr_state),
        .l2_req_valid(l2_req_valid), .l2_req_retry(l2_req_retry), .l2_req_cmd(l2_req_cmd),
        .l2_req_addr(l2_req_addr), .l2_req_way(l2_req_way), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_l2;
        logic [2:0]  way;
        logic [4:0]  set;
        logic [17:0] tag;
        logic [2:0]  st;
        logic [15:0] rrpv;
        logic [1:0]  cmd;
        logic [22:0] addr;
    } ev_t;

    typedef struct {
        logic [23:0] st;
        logic [15:0] rrpv;
        logic [17:0] tbase;
        logic [4:0]  set;
        logic [17:0] tag;
        logic        store;
        logic [2:0]  exp_way;
        logic [15:0] exp_aged;
        logic        exp_wb;
        int          passes;
    } vec_t;

    ev_t         q[$];
    vec_t        tbl[8];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, acc_cyc, tw_cyc, l2v_first;
    int          ack_dly = 1;
    logic [4:0]  cur_set;
    logic [4:0]  mcnt = '0;
    logic [23:0] bk_st = '0;
    logic [15:0] bk_rrpv = '0;
    logic [17:0] bk_tbase = '0;
    logic        prev_rdv = 1'b0, prev_l2v = 1'b0, prev_stall = 1'b0;
    logic [1:0]  s_cmd;
    logic [22:0] s_addr;
    logic [2:0]  s_way;
    ev_t         m_e;

    assign tag_rd_state = bk_st;
    assign tag_rd_rrpv  = bk_rrpv;
    always_comb begin
        tag_rd_tag = '0;
        for (int w = 0; w < 8; w++) tag_rd_tag[w*18 +: 18] = bk_tbase + 18'(w);
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [23:0] st8(input logic [2:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [15:0] rv8(input logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic vec_t mkv(input logic [23:0] st, input logic [15:0] rr, input logic [17:0] tb,
                                 input logic [4:0] s, input logic [17:0] t, input logic sto,
                                 input logic [2:0] w, input logic [15:0] aged, input logic wb, input int p);
        vec_t v;
        v.st = st; v.rrpv = rr; v.tbase = tb; v.set = s; v.tag = t; v.store = sto;
        v.exp_way = w; v.exp_aged = aged; v.exp_wb = wb; v.passes = p;
        return v;
    endfunction

    // Insertion value expected for the next accepted miss.
    function automatic logic [1:0] next_ins();
        logic [1:0] r;
`ifdef DC_VICTIM_BRRIP_EN
        r = (mcnt == 5'd0) ? 2'd2 : 2'd3;
`else
        r = 2'd2;
`endif
        mcnt = mcnt + 5'd1;
        return r;
    endfunction

    // Tag bank: ack ack_dly cycles after the read request.
    initial begin
        tag_rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (tag_rd_valid && !reset) begin
                @(posedge clk); #1;
                for (int i = 1; i < ack_dly; i++) begin @(posedge clk); #1; end
                tag_rd_ack = 1'b1;
                @(posedge clk); #1;
                tag_rd_ack = 1'b0;
            end
        end
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (reset) begin
            prev_rdv = 1'b0; prev_l2v = 1'b0; prev_stall = 1'b0;
        end else begin
            if (tag_rd_valid) begin
                check("rd_one_cycle", 64'(prev_rdv), 64'd0);
                check("rd_set", 64'(tag_rd_set), 64'(cur_set));
            end
            prev_rdv = tag_rd_valid;
            if (tag_wr_valid) begin
                tw_cyc = cyc;
                if (q.size() == 0) check("unexpected_tag_wr", 64'd1, 64'd0);
                else begin
                    m_e = q.pop_front();
                    check("tw_kind", 64'(m_e.is_l2), 64'd0);
                    check("tw_way", 64'(tag_wr_way), 64'(m_e.way));
                    check("tw_set", 64'(tag_wr_set), 64'(m_e.set));
                    check("tw_tag", 64'(tag_wr_tag), 64'(m_e.tag));
                    check("tw_state", 64'(tag_wr_state), 64'(m_e.st));
                    check("tw_rrpv", 64'(tag_wr_rrpv), 64'(m_e.rrpv));
                end
            end
            if (l2_req_valid) begin
                if (!prev_l2v) l2v_first = cyc;
                if (prev_stall) begin
                    check("stall_cmd", 64'(l2_req_cmd), 64'(s_cmd));
                    check("stall_addr", 64'(l2_req_addr), 64'(s_addr));
                    check("stall_way", 64'(l2_req_way), 64'(s_way));
                end
                if (l2_req_retry) begin
                    s_cmd = l2_req_cmd; s_addr = l2_req_addr; s_way = l2_req_way;
                    prev_stall = 1'b1;
                    check("stall_miss_retry", 64'(miss_retry), 64'd1);
                end else begin
                    prev_stall = 1'b0;
                    if (q.size() == 0) check("unexpected_l2_req", 64'd1, 64'd0);
                    else begin
                        m_e = q.pop_front();
                        check("l2_kind", 64'(m_e.is_l2), 64'd1);
                        check("l2_cmd", 64'(l2_req_cmd), 64'(m_e.cmd));
                        check("l2_addr", 64'(l2_req_addr), 64'(m_e.addr));
                        check("l2_way", 64'(l2_req_way), 64'(m_e.way));
                    end
                end
            end else begin
                if (prev_stall) check("stall_valid_dropped", 64'd0, 64'd1);
                prev_stall = 1'b0;
            end
            prev_l2v = l2_req_valid;
        end
    end

    task automatic run_miss(input vec_t v);
        ev_t         e;
        logic [15:0] er;
        int          t;
        bk_st = v.st; bk_rrpv = v.rrpv; bk_tbase = v.tbase; cur_set = v.set;
        er = v.exp_aged;
        er[2*v.exp_way +: 2] = next_ins();
        e.is_l2 = 1'b0; e.way = v.exp_way; e.set = v.set; e.tag = v.tag;
        e.st = v.store ? ST_M : ST_S; e.rrpv = er; e.cmd = '0; e.addr = '0;
        q.push_back(e);
        e.is_l2 = 1'b1;
        if (v.exp_wb) begin
            e.cmd = CMD_WB; e.addr = {v.tbase + 18'(v.exp_way), v.set};
            q.push_back(e);
        end
        e.cmd = v.store ? CMD_FILL_M : CMD_FILL_S; e.addr = {v.tag, v.set};
        q.push_back(e);
        tw_cyc = -1; l2v_first = -1;
        @(posedge clk); #1;
        miss_valid = 1'b1; miss_set = v.set; miss_tag = v.tag; miss_store = v.store;
        @(negedge clk);
        check("accept_ready", 64'(miss_retry), 64'd0);
        acc_cyc = cyc;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        t = 0;
        while ((busy || q.size() != 0) && t < 200) begin @(negedge clk); t++; end
        check("miss_timeout", 64'(t < 200), 64'd1);
        check("queue_drained", 64'(q.size()), 64'd0);
        check("lat_tag_wr", 64'(tw_cyc - acc_cyc), 64'(4 + v.passes));
        check("lat_l2_valid", 64'(l2v_first - acc_cyc), 64'(5 + v.passes));
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        reset = 1'b1; miss_valid = 1'b0; miss_set = '0; miss_tag = '0; miss_store = 1'b0;
        l2_req_retry = 1'b0; cur_set = '0;

        tbl[0] = mkv(st8(ST_S,ST_S,ST_S,ST_I,ST_S,ST_I,ST_S,ST_S), rv8(0,0,0,0,0,0,0,0), 18'h100,
                     5'd3, 18'h2ABCD, 1'b1, 3'd3, rv8(0,0,0,0,0,0,0,0), 1'b0, 0);
        tbl[1] = mkv(st8(ST_S,ST_S,ST_S,ST_I,ST_S,ST_I,ST_S,ST_S), rv8(1,2,0,1,2,0,1,2), 18'h180,
                     5'd17, 18'h00042, 1'b0, 3'd3, rv8(1,2,0,1,2,0,1,2), 1'b0, 0);
        tbl[2] = mkv(st8(ST_S,ST_S,ST_S,ST_S,ST_S,ST_S,ST_S,ST_S), rv8(0,0,1,0,0,1,0,1), 18'h200,
                     5'd9, 18'h3FFFF, 1'b0, 3'd2, rv8(2,2,3,2,2,3,2,3), 1'b0, 2);
        tbl[3] = mkv(st8(ST_S,ST_S,ST_S,ST_S,ST_S,ST_S,ST_M,ST_S), rv8(0,1,2,0,1,2,3,2), 18'h14F,
                     5'd21, 18'h12345, 1'b1, 3'd6, rv8(0,1,2,0,1,2,3,2), 1'b1, 0);
        tbl[4] = mkv(st8(ST_S,ST_S,ST_S,ST_S,ST_S,ST_S,ST_S,ST_S), rv8(0,0,0,0,0,0,0,0), 18'h000,
                     5'd31, 18'h00001, 1'b0, 3'd0, rv8(3,3,3,3,3,3,3,3), 1'b0, 3);
        tbl[5] = mkv(st8(ST_M,ST_M,ST_M,ST_M,ST_M,ST_M,ST_M,ST_I), rv8(3,3,3,3,3,3,3,0), 18'h040,
                     5'd0, 18'h00003, 1'b1, 3'd7, rv8(3,3,3,3,3,3,3,0), 1'b0, 0);
        tbl[6] = mkv(st8(ST_M,ST_M,ST_M,ST_M,ST_M,ST_M,ST_M,ST_M), rv8(2,2,2,2,2,3,2,3), 18'h3FFF0,
                     5'd12, 18'h0BEEF, 1'b0, 3'd5, rv8(2,2,2,2,2,3,2,3), 1'b1, 0);
        tbl[7] = mkv(st8(ST_I,ST_I,ST_I,ST_I,ST_I,ST_I,ST_I,ST_I), rv8(1,1,1,1,1,1,1,1), 18'h300,
                     5'd1, 18'h11111, 1'b1, 3'd0, rv8(1,1,1,1,1,1,1,1), 1'b0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({busy, miss_retry, tag_rd_valid, tag_wr_valid, l2_req_valid}), 64'd0);
        check("reset_l2_fields", 64'({l2_req_cmd, l2_req_addr, l2_req_way}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_miss(tbl[i]);

        // L2 back-pressure for four cycles on the fill.
        fork
            run_miss(tbl[1]);
            begin
                int t;
                t = 0;
                while (!l2_req_valid && t < 50) begin @(posedge clk); #1; t++; end
                l2_req_retry = 1'b1;
                repeat (4) @(posedge clk);
                #1 l2_req_retry = 1'b0;
            end
        join

        // Reset while waiting for the tag read; the late ack must be ignored.
        ack_dly = 4;
        bk_st = tbl[7].st; bk_rrpv = tbl[7].rrpv; cur_set = 5'd4;
        @(posedge clk); #1;
        miss_valid = 1'b1; miss_set = 5'd4; miss_tag = 18'h2222; miss_store = 1'b0;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mcnt = '0;
        @(negedge clk);
        check("reset_abort_idle", 64'({busy, miss_retry, tag_wr_valid, l2_req_valid}), 64'd0);
        spur = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tag_wr_valid || l2_req_valid || tag_rd_valid || busy) spur++;
        end
        check("reset_abort_quiet", 64'(spur), 64'd0);
        ack_dly = 1;

        // 33 misses from a freshly reset counter.
        for (int k = 0; k < 33; k++) begin
            vec_t v;
            v = tbl[7];
            v.tag = 18'(k + 18'h20);
            run_miss(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
